// File: rtl/latch_strobe_gen_pkg.sv
// Shared definitions for the pulse-based latch register bank: FSM state
// encoding, default strobe timing and a counter-width helper.
package latch_strobe_gen_pkg;

    // Write-strobe sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Default strobe timing in clk cycles.
    localparam int DEF_PULSE_W = 2;
    localparam int DEF_SETUP_W = 1;

    // Width of a down-counter that must hold max(pulse_w, setup_w) - 1.
    // Never narrower than one bit.
    function automatic int cnt_width(input int pulse_w, input int setup_w);
        int m;
        int w;
        m = (pulse_w > setup_w) ? pulse_w : setup_w;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/latch_strobe_gen_strb_decode.sv
// Registered index-to-one-hot decoder for the latch enables.
// en gates every output bit; all selects every bit (broadcast write).
// oor flags an index that addresses no latch.
module latch_strobe_gen_strb_decode
    import latch_strobe_gen_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int SEL_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             all,
    input  logic [SEL_W-1:0] idx,
    output logic             oor,
    output logic [NREG-1:0]  strb
);

    logic [NREG-1:0] hit;
    logic [NREG-1:0] strb_reg;

    // Index beyond the last latch: no bit matches, flag it instead.
    assign oor = ({1'b0, idx} >= (SEL_W + 1)'(NREG));

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_hit
            assign hit[gi] = all || (idx == SEL_W'(gi));
        end
    endgenerate

    // Latch enables come straight from flops so they can never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_reg <= '0;
        end else begin
            strb_reg <= en ? hit : '0;
        end
    end

    assign strb = strb_reg;

endmodule

// File: rtl/latch_strobe_gen.sv
// Write-strobe sequencer for the NAND D-latch register bank.
// Converts a req/ack write request plus register index into a fixed-width
// registered strobe on one latch enable, framed by setup and hold cycles.
// Optional feature macro: STRB_BROADCAST_EN (adds bcast input; a captured
// bcast strobes every latch and suppresses err).
module latch_strobe_gen
    import latch_strobe_gen_pkg::*;
#(
    parameter int NREG    = 8,
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int SETUP_W = DEF_SETUP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic [$clog2(NREG)-1:0] sel,
`ifdef STRB_BROADCAST_EN
    input  logic                    bcast,
`endif
    output logic                    ack,
    output logic                    err,
    output logic                    busy,
    output logic [NREG-1:0]         strb
);

    localparam int SEL_W = $clog2(NREG);
    localparam int CNT_W = cnt_width(PULSE_W, SETUP_W);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SETUP = SETUP;
    localparam logic [1:0] ST_PULSE = PULSE;
    localparam logic [1:0] ST_HOLD  = HOLD;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_W - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             bcast_reg, bcast_next;
    logic             ack_reg, err_reg, busy_reg;
    logic             bcast_in;
    logic             dec_en;
    logic             dec_oor;

`ifdef STRB_BROADCAST_EN
    assign bcast_in = bcast;
`else
    assign bcast_in = 1'b0;
`endif

    // Next-state logic: capture in IDLE, count down SETUP and PULSE,
    // single HOLD cycle, then always back through IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        bcast_next = bcast_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    sel_next   = sel;
                    bcast_next = bcast_in;
                    cnt_next   = SETUP_LOAD;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_reg == '0) begin
                    cnt_next   = PULSE_LOAD;
                    state_next = ST_PULSE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_HOLD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_HOLD: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counter and captured request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            sel_reg   <= '0;
            bcast_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            bcast_reg <= bcast_next;
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe, with no path from req or sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_reg  <= 1'b0;
            err_reg  <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next != ST_IDLE);
            ack_reg  <= (state_next == ST_HOLD);
            err_reg  <= (state_next == ST_HOLD) && dec_oor && !bcast_reg;
        end
    end

    // The decoder registers its output, so it is enabled for the cycles
    // that lead into PULSE; the strobe flops are then high exactly while
    // the FSM is in PULSE. sel_reg is already captured on SETUP entry.
    assign dec_en = (state_next == ST_PULSE);

    latch_strobe_gen_strb_decode #(
        .NREG  (NREG),
        .SEL_W (SEL_W)
    ) u_strb_decode (
        .clk  (clk),
        .rst  (rst),
        .en   (dec_en),
        .all  (bcast_reg),
        .idx  (sel_reg),
        .oor  (dec_oor),
        .strb (strb)
    );

    assign ack  = ack_reg;
    assign err  = err_reg;
    assign busy = busy_reg;

endmodule
